// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// over a shared datapath, stalls on mem_ready and counts retired instructions.
module mips_multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemToReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_RWB    = 4'd7,
        S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11
    } state_e;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic             retire;
    logic             unused_zero;

    // zero is consumed by the datapath (ANDed with PCWriteCond), not here.
    assign unused_zero = zero;

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:         state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_EXEC:   state_d = S_RWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        illegal_op  = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                illegal_op = !(opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_ADDIWB: RegWrite = 1'b1;
            default: ;
        endcase
        // Strobes must stay quiet for the whole reset pulse, even in FETCH.
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            RegWrite    = 1'b0;
            illegal_op  = 1'b0;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multi-cycle control FSM: state walks, strobes,
// memory stalls, async reset, illegal opcodes and counter wrap (CNT_W=4 copy).
module tb_mips_multicycle_control;
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000,
                           OP_BAD = 6'b111111;

    logic clk = 1'b0;
    logic reset, zero, mem_ready;
    logic [5:0] opcode;

    logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite;
    logic ALUSrcA, illegal_op;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;
    logic [31:0] retired;

    logic PCWrite4, PCWriteCond4, IorD4, MemRead4, MemWrite4, IRWrite4, MemToReg4, RegDst4, RegWrite4;
    logic ALUSrcA4, illegal_op4;
    logic [1:0] ALUSrcB4, ALUOp4, PCSource4;
    logic [3:0] state4;
    logic [3:0] retired4;

    int n_cmp = 0;
    int n_bad = 0;
    int irw_cnt = 0;
    int irw_snap;

    always #5 clk = ~clk;

    mips_multicycle_control #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .illegal_op(illegal_op), .state(state), .retired(retired)
    );

    mips_multicycle_control #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite4), .PCWriteCond(PCWriteCond4), .IorD(IorD4), .MemRead(MemRead4),
        .MemWrite(MemWrite4), .IRWrite(IRWrite4), .MemToReg(MemToReg4), .RegDst(RegDst4),
        .RegWrite(RegWrite4), .ALUSrcA(ALUSrcA4), .ALUSrcB(ALUSrcB4), .ALUOp(ALUOp4),
        .PCSource(PCSource4), .illegal_op(illegal_op4), .state(state4), .retired(retired4)
    );

    always @(posedge clk) if (IRWrite) irw_cnt++;

    function automatic logic [31:0] strobes();
        return 32'({PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite, illegal_op});
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then drive this cycle's inputs and let outputs settle.
    task automatic tick(input logic mr, input logic [5:0] op);
        @(posedge clk);
        #1;
        mem_ready = mr;
        opcode    = op;
        #1;
    endtask

    initial begin
        reset = 1'b1; zero = 1'b0; mem_ready = 1'b0; opcode = OP_R;
        #2;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_strobes", strobes(), 32'd0);
        mem_ready = 1'b1; #1;
        chk("rst_strobes_mr1", strobes(), 32'd0);
        chk("rst_alusrcb", 32'(ALUSrcB), 32'd1);
        tick(1'b1, OP_R);
        reset = 1'b0; #1;
        chk("post_rst_irwrite", 32'(IRWrite), 32'd1);
        chk("post_rst_pcwrite", 32'(PCWrite), 32'd1);
        chk("fetch_memread", 32'(MemRead), 32'd1);

        // R-type
        tick(1'b1, OP_R); chk("r_s1", 32'(state), 32'd1);
        chk("r_dec_alusrcb", 32'(ALUSrcB), 32'd3);
        tick(1'b1, OP_R); chk("r_s6", 32'(state), 32'd6);
        chk("r_exec_aluop", 32'(ALUOp), 32'd2);
        chk("r_exec_regwrite", 32'(RegWrite), 32'd0);
        tick(1'b1, OP_R); chk("r_s7", 32'(state), 32'd7);
        chk("r_rwb_regwrite", 32'(RegWrite), 32'd1);
        chk("r_rwb_regdst", 32'(RegDst), 32'd1);
        tick(1'b1, OP_R); chk("r_s0", 32'(state), 32'd0);
        chk("r_retired", retired, 32'd1);

        // lw with 2 FETCH waits and 3 MEMRD waits
        mem_ready = 1'b0; opcode = OP_LW; irw_snap = irw_cnt; #1;
        chk("lw_f0", 32'(state), 32'd0);
        chk("lw_f0_irwrite", 32'(IRWrite), 32'd0);
        tick(1'b0, OP_LW); chk("lw_f1", 32'(state), 32'd0);
        chk("lw_f1_memread", 32'(MemRead), 32'd1);
        tick(1'b1, OP_LW); chk("lw_f2", 32'(state), 32'd0);
        chk("lw_f2_irwrite", 32'(IRWrite), 32'd1);
        tick(1'b0, OP_LW); chk("lw_s1", 32'(state), 32'd1);
        tick(1'b0, OP_LW); chk("lw_s2", 32'(state), 32'd2);
        chk("lw_madr_alusrcb", 32'(ALUSrcB), 32'd2);
        chk("lw_madr_alusrca", 32'(ALUSrcA), 32'd1);
        tick(1'b0, OP_LW); chk("lw_s3a", 32'(state), 32'd3);
        chk("lw_memrd_iord", 32'(IorD), 32'd1);
        tick(1'b0, OP_LW); chk("lw_s3b", 32'(state), 32'd3);
        tick(1'b0, OP_LW); chk("lw_s3c", 32'(state), 32'd3);
        chk("lw_wait_memread", 32'(MemRead), 32'd1);
        tick(1'b1, OP_LW); chk("lw_s3d", 32'(state), 32'd3);
        tick(1'b1, OP_LW); chk("lw_s4", 32'(state), 32'd4);
        chk("lw_memtoreg", 32'(MemToReg), 32'd1);
        chk("lw_regwrite", 32'(RegWrite), 32'd1);
        chk("lw_regdst", 32'(RegDst), 32'd0);
        tick(1'b1, OP_LW); chk("lw_s0", 32'(state), 32'd0);
        chk("lw_retired", retired, 32'd2);
        chk("lw_irwrite_once", 32'(irw_cnt - irw_snap), 32'd1);

        // lw abandoned by async reset while stalled in MEMRD
        tick(1'b1, OP_LW); tick(1'b1, OP_LW);
        tick(1'b0, OP_LW); chk("ar_s3", 32'(state), 32'd3);
        reset = 1'b1; #1;
        chk("ar_state", 32'(state), 32'd0);
        chk("ar_retired", retired, 32'd0);
        chk("ar_strobes", strobes(), 32'd0);
        tick(1'b1, OP_SW); chk("ar_hold_strobes", strobes(), 32'd0);
        reset = 1'b0; #1;
        chk("ar_rel_irwrite", 32'(IRWrite), 32'd1);
        chk("ar_rel_pcwrite", 32'(PCWrite), 32'd1);

        // sw (one MEMWR wait), beq, j
        tick(1'b1, OP_SW); chk("sw_s1", 32'(state), 32'd1);
        tick(1'b1, OP_SW); chk("sw_s2", 32'(state), 32'd2);
        tick(1'b0, OP_SW); chk("sw_s5", 32'(state), 32'd5);
        chk("sw_memwrite", 32'(MemWrite), 32'd1);
        chk("sw_regwrite", 32'(RegWrite), 32'd0);
        tick(1'b1, OP_SW); chk("sw_s5_hold", 32'(state), 32'd5);
        chk("sw_wait_retired", retired, 32'd0);
        tick(1'b1, OP_BEQ); chk("sw_s0", 32'(state), 32'd0);
        chk("sw_retired", retired, 32'd1);
        chk("fetch_memwrite", 32'(MemWrite), 32'd0);
        tick(1'b1, OP_BEQ); chk("beq_s1", 32'(state), 32'd1);
        tick(1'b1, OP_BEQ); chk("beq_s8", 32'(state), 32'd8);
        chk("beq_pcwc", 32'(PCWriteCond), 32'd1);
        chk("beq_aluop", 32'(ALUOp), 32'd1);
        chk("beq_pcsrc", 32'(PCSource), 32'd1);
        tick(1'b1, OP_J); chk("beq_s0", 32'(state), 32'd0);
        chk("beq_retired", retired, 32'd2);
        tick(1'b1, OP_J); chk("j_s1", 32'(state), 32'd1);
        tick(1'b1, OP_J); chk("j_s9", 32'(state), 32'd9);
        chk("j_pcwrite", 32'(PCWrite), 32'd1);
        chk("j_pcsrc", 32'(PCSource), 32'd2);
        tick(1'b1, OP_BAD); chk("j_s0", 32'(state), 32'd0);
        chk("j_retired", retired, 32'd3);

        // illegal opcode
        tick(1'b1, OP_BAD); chk("ill_s1", 32'(state), 32'd1);
        chk("ill_flag", 32'(illegal_op), 32'd1);
        chk("ill_regwrite", 32'(RegWrite), 32'd0);
        chk("ill_memwrite", 32'(MemWrite), 32'd0);
        tick(1'b1, OP_ADDI); chk("ill_s0", 32'(state), 32'd0);
        chk("ill_flag_clr", 32'(illegal_op), 32'd0);
        chk("ill_retired", retired, 32'd3);

        // 17 addi on the 4-bit counter copy
        reset = 1'b1; #1; reset = 1'b0; #1;
        chk("addi_rst4", 32'(retired4), 32'd0);
        for (int k = 1; k <= 17; k++) begin
            tick(1'b1, OP_ADDI); chk("addi_s1", 32'(state4), 32'd1);
            tick(1'b1, OP_ADDI); chk("addi_s10", 32'(state4), 32'd10);
            tick(1'b1, OP_ADDI); chk("addi_s11", 32'(state4), 32'd11);
            if (k == 1) chk("addi_regwrite", 32'(RegWrite4), 32'd1);
            tick(1'b1, OP_ADDI); chk("addi_s0", 32'(state4), 32'd0);
            if (k == 15) chk("addi_ret15", 32'(retired4), 32'd15);
            if (k == 16) chk("addi_ret16", 32'(retired4), 32'd0);
            if (k == 17) chk("addi_ret17", 32'(retired4), 32'd1);
        end
        chk("addi_ret32", retired, 32'd17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multi-cycle MIPS control unit. Moore FSM that sequences the shared datapath (one memory, one ALU, register file, PC, IR) across FETCH/DECODE/EXECUTE/MEM/WB steps.
- Replaces the single-cycle decoder for the multi-cycle core. Supports R-type, lw, sw, beq, j and addi, using the same opcodes and ALUOp encoding: 00 add, 01 sub, 10 funct.
- Inserts memory wait states through a mem_ready handshake, flags illegal opcodes, and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  6  instr[31:26] from IR; valid from DECODE onward.
- zero  input  1  ALU zero flag. Informational only; the datapath ANDs it with PCWriteCond.
- mem_ready  input  1  memory completes the current access this cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load if zero (beq).
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  IR load.
- MemToReg  output  1  write-back data select: 1 = MDR, 0 = ALUOut.
- RegDst  output  1  destination register select: 1 = rd, 0 = rt.
- RegWrite  output  1  register-file write.
- ALUSrcA  output  1  ALU operand A select: 0 = PC, 1 = A.
- ALUSrcB  output  2  ALU operand B select: 00 = B, 01 = 4, 10 = signext imm, 11 = signext imm << 2.
- ALUOp  output  2  00 add, 01 sub, 10 funct.
- PCSource  output  2  PC input select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal_op  output  1  high during DECODE when opcode is unsupported.
- state  output  4  current state encoding, for debug.
- retired  output  CNT_W  retired-instruction count.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11. Encodings 12-15 are unreachable; if entered, go to FETCH.
- Reset, asynchronous:
  - state=FETCH, retired=0.
  - While reset is high, every strobe (PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite) and illegal_op is 0.
  - All selects are 0 except those driven by the FETCH defaults.
  - Reset mid-instruction abandons it with no write and no count.
- Outputs are decoded from state only, plus mem_ready gating in FETCH. Unlisted outputs are 0.
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=mem_ready.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMRD: MemRead=1, IorD=1.
  - MEMWB: RegWrite=1, MemToReg=1, RegDst=0.
  - MEMWR: MemWrite=1, IorD=1.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - RWB: RegWrite=1, RegDst=1, MemToReg=0.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
  - JUMP: PCWrite=1, PCSource=10.
  - ADDIWB: RegWrite=1, RegDst=0, MemToReg=0.
- Transitions:
  - FETCH goes to DECODE if mem_ready, else stays in FETCH.
  - DECODE branches on opcode:
    - 000000 goes to EXEC.
    - 100011 and 101011 go to MEMADR.
    - 000100 goes to BRANCH.
    - 000010 goes to JUMP.
    - 001000 goes to ADDIEX.
    - Any other opcode asserts illegal_op for that cycle and goes to FETCH.
  - MEMADR goes to MEMRD for lw and MEMWR for sw. opcode is held stable by IR.
  - MEMRD goes to MEMWB if mem_ready, else holds. MEMWR goes to FETCH if mem_ready, else holds.
  - MEMWB, RWB, BRANCH, JUMP and ADDIWB go to FETCH.
  - EXEC goes to RWB. ADDIEX goes to ADDIWB.
- Latency with mem_ready=1 throughout, counted from entering FETCH:
  - lw: 5 cycles.
  - R-type, sw, addi: 4 cycles.
  - beq, j: 3 cycles.
  - Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle.
- Memory strobes are held constant while waiting. The IR/PC load in FETCH happens exactly once, in the cycle mem_ready=1.
- retired increments by 1 on the clock edge leaving any of:
  - MEMWB, RWB, BRANCH, JUMP, ADDIWB;
  - MEMWR when mem_ready=1.
- A beq counts whether or not it is taken. An illegal opcode is not counted.
- retired wraps modulo 2^CNT_W.

Test Plan:
- Reset asserted asynchronously mid-MEMRD -> state=0, retired=0, and all strobes 0 immediately. After release with mem_ready=1: IRWrite=PCWrite=1 in the first cycle.
- R-type (opcode 000000), mem_ready=1 -> states 0,1,6,7,0. RegWrite=1 with RegDst=1 only in state 7. retired 0 goes to 1.
- lw (100011), mem_ready low for 2 cycles in FETCH and 3 cycles in MEMRD -> states 0,0,0,1,2,3,3,3,3,4,0. IRWrite pulses exactly once. MemToReg=1 in state 4.
- sw then beq then j, mem_ready=1 ->
  - sw: MemWrite=1 only in state 5, RegWrite never 1.
  - beq: PCWriteCond=1, ALUOp=01, PCSource=01 in state 8.
  - j: PCWrite=1, PCSource=10 in state 9.
  - retired goes 0 to 3.
- Illegal opcode 111111 -> illegal_op=1 for one cycle in DECODE, next state 0, no RegWrite/MemWrite, retired unchanged.
- CNT_W=4, run 17 addi (001000) instructions -> states 0,1,10,11 each time. retired reads 15, then 0, then 1.
